// File: rtl/l1_icache_assoc.sv
// N-way set-associative L1 instruction cache with true-LRU replacement,
// zero-latency hits, single-line refill from memory and whole-cache flush.
module l1_icache_assoc #(
    parameter int WAYS        = 4,
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cpu_req_i,
    input  logic [31:0]                 pc_i,
    input  logic                        flush_i,
    output logic                        cpu_ready_o,
    output logic [31:0]                 instr_o,
    output logic                        mem_valid_o,
    output logic [31:0]                 mem_addr_o,
    input  logic                        mem_ready_i,
    input  logic [32*BLOCK_WORDS-1:0]   mem_rdata_i,
    output logic                        busy_o,
    output logic [31:0]                 hit_cnt_o,
    output logic [31:0]                 miss_cnt_o,
    output logic [1:0]                  dbg_state_o
);

    localparam int OFF_W  = $clog2(BLOCK_WORDS) + 2;
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - SET_W - OFF_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int LINE_W = 32 * BLOCK_WORDS;

    typedef enum logic [1:0] {
        S_LOOKUP = 2'd0,
        S_REFILL = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Storage: valid bits and LRU ranks are reset, tags and data are not.
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAY_W-1:0]  rank_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    logic [TAG_W+SET_W-1:0] miss_addr_q;
    logic                   pending_flush_q;
    logic [SET_W-1:0]       flush_idx_q;
    logic [31:0]            hit_cnt_q;
    logic [31:0]            miss_cnt_q;

    logic [TAG_W-1:0]  req_tag;
    logic [SET_W-1:0]  req_set;
    logic [WORD_W-1:0] req_word;
    logic [TAG_W-1:0]  miss_tag;
    logic [SET_W-1:0]  miss_set;

    assign req_tag  = pc_i[31 -: TAG_W];
    assign req_set  = pc_i[OFF_W +: SET_W];
    assign req_word = pc_i[2 +: WORD_W];
    assign miss_set = miss_addr_q[SET_W-1:0];
    assign miss_tag = miss_addr_q[SET_W +: TAG_W];

    // Byte-offset bits are meaningless for word-aligned fetches.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc_i[1:0]};

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [LINE_W-1:0] hit_line;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_q[req_set][hit_way];

    logic lookup_hit;
    logic miss_start;
    logic fill_en;

    assign lookup_hit = (state_q == S_LOOKUP) && cpu_req_i && hit;
    assign miss_start = (state_q == S_LOOKUP) && cpu_req_i && !hit && !flush_i;
    assign fill_en    = (state_q == S_REFILL) && mem_ready_i;

    // Victim: lowest-index invalid way, otherwise the way holding the oldest rank.
    logic [WAY_W-1:0] victim;
    logic             found_invalid;

    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_q[miss_set][w]) begin
                found_invalid = 1'b1;
                victim        = WAY_W'(w);
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (rank_q[miss_set][w] == WAY_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    logic             access_en;
    logic [SET_W-1:0] access_set;
    logic [WAY_W-1:0] access_way;

    assign access_en  = lookup_hit || fill_en;
    assign access_set = fill_en ? miss_set : req_set;
    assign access_way = fill_en ? victim   : hit_way;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOOKUP: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                end else if (cpu_req_i && !hit) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_ready_i) begin
                    state_d = (pending_flush_q || flush_i) ? S_FLUSH : S_LOOKUP;
                end
            end
            S_FLUSH: begin
                if (flush_idx_q == SET_W'(SETS - 1)) begin
                    state_d = S_LOOKUP;
                end
            end
            default: state_d = S_LOOKUP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_LOOKUP;
            miss_addr_q     <= '0;
            pending_flush_q <= 1'b0;
            flush_idx_q     <= '0;
            hit_cnt_q       <= '0;
            miss_cnt_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    rank_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            state_q <= state_d;

            if (miss_start) begin
                miss_addr_q <= {req_tag, req_set};
            end

            if (state_q == S_REFILL) begin
                if (mem_ready_i) begin
                    pending_flush_q <= 1'b0;
                end else if (flush_i) begin
                    pending_flush_q <= 1'b1;
                end
            end else begin
                pending_flush_q <= 1'b0;
            end

            if (state_q == S_FLUSH) begin
                flush_idx_q <= flush_idx_q + 1'b1;
            end else begin
                flush_idx_q <= '0;
            end

            if (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end

            if (fill_en) begin
                valid_q[miss_set][victim] <= 1'b1;
            end

            // Ways younger than the accessed one age by one; accessed way becomes MRU.
            if (access_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == access_way) begin
                        rank_q[access_set][w] <= '0;
                    end else if (rank_q[access_set][w] < rank_q[access_set][access_way]) begin
                        rank_q[access_set][w] <= rank_q[access_set][w] + 1'b1;
                    end
                end
            end

            if (state_q == S_FLUSH) begin
                valid_q[flush_idx_q] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    rank_q[flush_idx_q][w] <= WAY_W'(w);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_q[miss_set][victim] <= mem_rdata_i;
            tag_q[miss_set][victim]  <= miss_tag;
        end
    end

    // Memory handshake: mem_valid_o and mem_addr_o hold steady from entry into
    // REFILL until the cycle mem_ready_i is high; that cycle transfers the line.
    assign mem_valid_o = (state_q == S_REFILL);
    assign mem_addr_o  = {miss_addr_q, {OFF_W{1'b0}}};

    assign cpu_ready_o = lookup_hit;
    assign instr_o     = hit_line[32*req_word +: 32];
    assign busy_o      = (state_q != S_LOOKUP);
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_l1_icache_assoc.sv
// Directed bench for l1_icache_assoc with default geometry (4 ways, 8 sets, 4-word lines)
// and a latency-programmable memory responder.
module tb_l1_icache_assoc;

    logic         clk;
    logic         rst_n;
    logic         cpu_req;
    logic [31:0]  pc;
    logic         flush;
    logic         cpu_ready_o;
    logic [31:0]  instr_o;
    logic         mem_valid_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ready_i;
    logic [127:0] mem_rdata_i;
    logic         busy_o;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
    logic [1:0]   dbg_state_o;

    int n_checks;
    int n_errors;
    int exp_hits;
    int exp_misses;
    int mem_lat;
    logic mem_hold;
    int wait_cnt;

    l1_icache_assoc dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_req_i   (cpu_req),
        .pc_i        (pc),
        .flush_i     (flush),
        .cpu_ready_o (cpu_ready_o),
        .instr_o     (instr_o),
        .mem_valid_o (mem_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        if (a == 32'h0000_0100) begin
            l = {32'h44, 32'h33, 32'h22, 32'h11};
        end else begin
            for (int k = 0; k < 4; k++) begin
                l[k*32 +: 32] = (a + 32'(4 * k)) ^ 32'hC0DE_0000;
            end
        end
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [127:0] l;
        l = line_of({a[31:4], 4'b0000});
        return l[32*a[3:2] +: 32];
    endfunction

    // Memory responder: ready arrives after mem_lat cycles of mem_valid_o.
    always @(negedge clk) begin
        if (!mem_valid_o || mem_ready_i) begin
            mem_ready_i = 1'b0;
            wait_cnt    = 0;
        end else begin
            wait_cnt++;
            if (wait_cnt > mem_lat && !mem_hold) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = line_of(mem_addr_o);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        flush   = 1'b0;
        pc      = '0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, " hit_cnt"}, hit_cnt_o, 32'(exp_hits));
        check_eq({tag, " miss_cnt"}, miss_cnt_o, 32'(exp_misses));
    endtask

    // Fetch one word; on a miss, waits for the refill and checks address and latency.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic exp_hit);
        int cyc;
        logic [31:0] seen_addr;
        @(negedge clk);
        cpu_req = 1'b1;
        pc      = addr;
        #1;
        check_eq({tag, " hit"}, {31'b0, cpu_ready_o}, {31'b0, exp_hit});
        if (!cpu_ready_o) begin
            exp_misses++;
            cyc       = 0;
            seen_addr = 32'hDEAD_BEEF;
            while (!cpu_ready_o && cyc < 100) begin
                @(negedge clk);
                #1;
                cyc++;
                if (mem_valid_o) seen_addr = mem_addr_o;
            end
            check_eq({tag, " latency"}, 32'(cyc), 32'(mem_lat + 2));
            check_eq({tag, " mem_addr"}, seen_addr, {addr[31:4], 4'b0000});
        end else begin
            check_eq({tag, " no mem req"}, {31'b0, mem_valid_o}, 32'd0);
        end
        if (cpu_ready_o) exp_hits++;
        check_eq({tag, " instr"}, instr_o, word_of(addr));
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic count_busy(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        #1;
        while (busy_o && cnt < 40) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check_eq({tag, " busy cycles"}, 32'(cnt), 32'(exp_cycles));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        mem_lat     = 3;
        mem_hold    = 1'b0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        wait_cnt    = 0;
        do_reset();

        // Reset state
        #1;
        check_eq("reset cpu_ready", {31'b0, cpu_ready_o}, 32'd0);
        check_eq("reset mem_valid", {31'b0, mem_valid_o}, 32'd0);
        check_eq("reset busy", {31'b0, busy_o}, 32'd0);
        check_counters("reset");

        // Cold miss then line reuse
        fetch("cold 0x104", 32'h0000_0104, 1'b0);
        check_eq("cold instr const", instr_o, 32'h22);
        check_counters("after cold");
        fetch("reuse 0x100", 32'h0000_0100, 1'b1);
        fetch("reuse 0x108", 32'h0000_0108, 1'b1);
        fetch("reuse 0x10C", 32'h0000_010C, 1'b1);
        check_counters("after reuse");

        // LRU eviction in set 0
        do_reset();
        mem_lat = 1;
        fetch("lru fill 0x000", 32'h0000_0000, 1'b0);
        fetch("lru fill 0x080", 32'h0000_0080, 1'b0);
        fetch("lru fill 0x100", 32'h0000_0100, 1'b0);
        fetch("lru fill 0x180", 32'h0000_0180, 1'b0);
        fetch("lru touch 0x000", 32'h0000_0000, 1'b1);
        fetch("lru new 0x200", 32'h0000_0200, 1'b0);
        fetch("lru 0x100 kept", 32'h0000_0104, 1'b1);
        fetch("lru 0x080 evicted", 32'h0000_0084, 1'b0);
        fetch("lru 0x000 kept", 32'h0000_0008, 1'b1);
        fetch("lru other set 0x010", 32'h0000_0010, 1'b0);
        check_counters("after lru");

        // Whole-cache flush
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        count_busy("flush", 8);
        fetch("post flush 0x000", 32'h0000_0000, 1'b0);
        fetch("post flush 0x010", 32'h0000_0010, 1'b0);
        fetch("post flush 0x200", 32'h0000_0200, 1'b0);
        check_counters("after flush");

        // Flush requested while the refill is stalled
        mem_hold = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1;
        pc      = 32'h0000_0300;
        #1;
        check_eq("fdr miss", {31'b0, cpu_ready_o}, 32'd0);
        exp_misses++;
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check_eq("fdr mem_valid", {31'b0, mem_valid_o}, 32'd1);
        check_eq("fdr mem_addr", mem_addr_o, 32'h0000_0300);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("fdr still refilling", {31'b0, mem_valid_o}, 32'd1);
        mem_hold = 1'b0;
        begin
            int cnt;
            cnt = 0;
            while (mem_valid_o && cnt < 40) begin
                @(negedge clk);
                #1;
                cnt++;
            end
            check_eq("fdr refill done", {31'b0, mem_valid_o}, 32'd0);
        end
        count_busy("fdr flush", 8);
        fetch("fdr refilled line", 32'h0000_0300, 1'b0);
        check_counters("after fdr");

        // Asynchronous reset during a refill
        mem_hold = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1;
        pc      = 32'h0000_0400;
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check_eq("rst mid mem_valid before", {31'b0, mem_valid_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst mid mem_valid", {31'b0, mem_valid_o}, 32'd0);
        check_eq("rst mid busy", {31'b0, busy_o}, 32'd0);
        exp_hits   = 0;
        exp_misses = 0;
        check_counters("rst mid");
        @(negedge clk);
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        mem_lat  = 2;
        fetch("rst next fetch", 32'h0000_0104, 1'b0);
        check_counters("after rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
